reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 4: number of downstream reset domains, legal range 2..8.
REQ-002 The block SHALL have parameter LOCK_FILTER, default 16: consecutive cycles lock_in must be high before it is treated as locked, legal range 2..255.
REQ-003 The block SHALL have parameter STEP_DELAY, default 8: cycles between successive domain release or assertion steps, legal range 1..255.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 32: cycles all domains stay held after a soft reset before re-sequencing, legal range 1..255.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port lock_in, input, width 1: clock-source locked indication, already synchronous to clk.
REQ-008 The block SHALL have port soft_rst_req, input, width 1: single-cycle request for an orderly re-reset.
REQ-009 The block SHALL have port domain_resn_out, output, width NUM_DOMAINS: active-low reset per domain; bit 0 releases first.
REQ-010 The block SHALL have port seq_done, output, width 1: high only in state RUN.
REQ-011 The block SHALL have port busy, output, width 1: high in every state except RUN and WAIT_LOCK.

Function
REQ-012 The FSM SHALL have exactly the states WAIT_LOCK, FILTER, RELEASE, RUN, ASSERT and HOLD.
REQ-013 In WAIT_LOCK, all domain_resn_out bits SHALL be 0, and the FSM SHALL move to FILTER on the first cycle lock_in=1.
REQ-014 In FILTER, a counter SHALL count consecutive cycles of lock_in=1.
REQ-015 In FILTER, lock_in=0 SHALL return the FSM to WAIT_LOCK and clear the counter.
REQ-016 In FILTER, reaching LOCK_FILTER consecutive high cycles SHALL move the FSM to RELEASE with step index 0.
REQ-017 In RELEASE, the FSM SHALL set domain_resn_out[idx]=1 on entry and on each subsequent step, then wait STEP_DELAY cycles before the next step.
REQ-018 In RELEASE, after bit NUM_DOMAINS-1 is set and STEP_DELAY cycles have elapsed, the FSM SHALL enter RUN.
REQ-019 Releases SHALL be monotonic: a bit, once released, stays 1 until ASSERT, HOLD or a lock-loss event.
REQ-020 In RUN, all bits SHALL be 1 and seq_done SHALL be 1.
REQ-021 Lock loss (lock_in=0) in any state other than WAIT_LOCK SHALL, on the next edge, clear all domain_resn_out bits, clear all counters and move the FSM to WAIT_LOCK; this takes priority over soft_rst_req.
REQ-022 soft_rst_req=1 in RUN or RELEASE SHALL move the FSM to ASSERT.
REQ-023 ASSERT SHALL clear bits in reverse order, starting from the highest currently released bit down to bit 0, with STEP_DELAY cycles between clears.
REQ-024 In ASSERT, the first clear SHALL occur on the edge that enters the state.
REQ-025 After bit 0 is cleared, the FSM SHALL enter HOLD.
REQ-026 HOLD SHALL keep all bits at 0 for HOLD_CYCLES cycles, then enter FILTER with a cleared counter.
REQ-027 soft_rst_req SHALL be ignored in WAIT_LOCK, FILTER, ASSERT and HOLD; it is not latched or queued.
REQ-028 Every step-delay and hold counter SHALL be 8 bits wide, count from 0 and terminate at value-1 with no wrap beyond.
REQ-029 The step index SHALL be $clog2(NUM_DOMAINS) bits wide and SHALL never exceed NUM_DOMAINS-1.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While rst=1 at a clk edge, the FSM SHALL be WAIT_LOCK, domain_resn_out SHALL be all 0, seq_done=0, busy=0, and all counters and the index SHALL be 0.
REQ-032 Reset asserted mid-RELEASE or mid-ASSERT SHALL abort the sequence immediately with the REQ-031 values on the next edge.
REQ-033 rst SHALL have priority over lock_in and soft_rst_req.

Verification
REQ-034 The bench SHALL cover power-up: rst for 3 cycles, then lock_in=1 held -> domain_resn_out steps 0000->0001->0011->0111->1111, with bit 0 at cycle 17 after the first lock_in=1 cycle and 8 cycles between steps; seq_done=1 8 cycles after bit 3.
REQ-035 The bench SHALL cover a lock glitch in FILTER: lock_in low for 1 cycle at filter count 10 -> return to WAIT_LOCK, and the full 16-cycle filter restarts.
REQ-036 The bench SHALL cover soft reset in RUN: 1-cycle soft_rst_req -> 1111->0111->0011->0001->0000 at 8-cycle spacing, then 32 cycles of 0000, then re-filter and re-release.
REQ-037 The bench SHALL cover lock loss during RELEASE at 0011 -> next edge gives 0000 with seq_done=0 and busy=0.
REQ-038 The bench SHALL cover soft_rst_req during RELEASE at 0011 -> ASSERT clears bit 1 then bit 0, and bits 2 and 3 never become 1.
REQ-039 The bench SHALL cover rst asserted during ASSERT at 0111 -> next edge gives all 0, state WAIT_LOCK, and soft_rst_req held high alongside it has no effect.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release/assertion for NUM_DOMAINS downstream domains.
// Waits for a filtered clock lock, releases domains low-to-high, and on a
// soft reset request re-asserts them high-to-low, holds, then re-sequences.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int LOCK_FILTER = 16,
  parameter int STEP_DELAY  = 8,
  parameter int HOLD_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lock_in,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_resn_out,
  output logic                   seq_done,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS);
  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    ASSERT    = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] filt_cnt;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] idx_dec;

  // Neighbouring step indices used by release and assert stepping.
  always_comb begin
    idx_inc = idx + IDX_W'(1);
    idx_dec = idx - IDX_W'(1);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || (state != WAIT_LOCK && !lock_in)) begin
      // Reset and lock loss both abandon everything immediately.
      state           <= WAIT_LOCK;
      domain_resn_out <= '0;
      seq_done        <= 1'b0;
      busy            <= 1'b0;
      filt_cnt        <= '0;
      step_cnt        <= '0;
      hold_cnt        <= '0;
      idx             <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_in) begin
            state    <= FILTER;
            busy     <= 1'b1;
            filt_cnt <= '0;
          end
        end

        FILTER: begin
          // lock_in is known high here; low was handled above.
          if (filt_cnt == FILT_LAST) begin
            state              <= RELEASE;
            filt_cnt           <= '0;
            step_cnt           <= '0;
            idx                <= '0;
            domain_resn_out[0] <= 1'b1;
          end else begin
            filt_cnt <= filt_cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (soft_rst_req) begin
            // Highest released bit is idx; clear it on this edge.
            domain_resn_out[idx] <= 1'b0;
            step_cnt             <= '0;
            hold_cnt             <= '0;
            state                <= (idx == '0) ? HOLD : ASSERT;
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if (idx == LAST_IDX) begin
              state    <= RUN;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              idx                      <= idx_inc;
              domain_resn_out[idx_inc] <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (soft_rst_req) begin
            state                <= ASSERT;
            seq_done             <= 1'b0;
            busy                 <= 1'b1;
            step_cnt             <= '0;
            domain_resn_out[idx] <= 1'b0;
          end
        end

        ASSERT: begin
          // idx is always >= 1 here; bit 0 clearing moves straight to HOLD.
          if (step_cnt == STEP_LAST) begin
            step_cnt                 <= '0;
            idx                      <= idx_dec;
            domain_resn_out[idx_dec] <= 1'b0;
            if (idx_dec == '0) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= FILTER;
            hold_cnt <= '0;
            filt_cnt <= '0;
            idx      <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        default: begin
          state           <= WAIT_LOCK;
          domain_resn_out <= '0;
          seq_done        <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule
